// File: rtl/riscv_dmem_ctrl.sv
// M-stage data-memory controller: aligns loads/stores onto a 32-bit request/ack bus,
// stalls the pipeline until the bus answers (or times out) and returns the raw read word.
module riscv_dmem_ctrl #(
  parameter int MP_DATA_WIDTH = 32,
  parameter int MP_ADDR_WIDTH = 32,
  parameter int MP_TIMEOUT    = 255
) (
  input  logic                     iclk,
  input  logic                     irst,
  input  logic                     imem_wr_m,
  input  logic                     imem_rd_m,
  input  logic [2:0]               ifunct3_m,
  input  logic [MP_ADDR_WIDTH-1:0] iaddr_m,
  input  logic [MP_DATA_WIDTH-1:0] iwdata_m,
  output logic [MP_DATA_WIDTH-1:0] ordata_m,
  output logic                     ostall_m,
  output logic                     omisalign_m,
  output logic                     otimeout_m,
  output logic                     obus_req,
  output logic                     obus_we,
  output logic [MP_ADDR_WIDTH-1:0] obus_addr,
  output logic [3:0]               obus_be,
  output logic [MP_DATA_WIDTH-1:0] obus_wdata,
  input  logic                     ibus_ack,
  input  logic [MP_DATA_WIDTH-1:0] ibus_rdata
);

  localparam int CNT_W = $clog2(MP_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q;
  logic                     req_q, we_q, timeout_q;
  logic [MP_ADDR_WIDTH-1:0] addr_q;
  logic [3:0]               be_q;
  logic [MP_DATA_WIDTH-1:0] wdata_q, rdata_q;

  logic                     req, misalign, launch, timeout_hit;
  logic [3:0]               be_d;
  logic [MP_DATA_WIDTH-1:0] wdata_d;

  // Sign/zero extension happens in the datapath, so the unsigned bit is not needed here.
  logic unused_funct3;
  assign unused_funct3 = ifunct3_m[2];

  assign req         = imem_wr_m | imem_rd_m;
  assign launch      = (state_q == S_IDLE) && req && !misalign;
  assign timeout_hit = !ibus_ack && (cnt_q == CNT_W'(MP_TIMEOUT - 1));

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    misalign = 1'b0;
    be_d     = 4'b0000;
    wdata_d  = iwdata_m;
    unique case (ifunct3_m[1:0])
      2'b00: begin
        be_d    = 4'b0001 << iaddr_m[1:0];
        wdata_d = {4{iwdata_m[7:0]}};
      end
      2'b01: begin
        misalign = iaddr_m[0];
        be_d     = 4'b0011 << {iaddr_m[1], 1'b0};
        wdata_d  = {2{iwdata_m[15:0]}};
      end
      2'b10: begin
        misalign = |iaddr_m[1:0];
        be_d     = 4'b1111;
      end
      default: misalign = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge iclk) begin
    if (irst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (launch) state_d = S_BUSY;
      S_BUSY:  if (ibus_ack || timeout_hit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ostall_m    = (state_q == S_BUSY) || launch;
    omisalign_m = (state_q == S_IDLE) && req && misalign;
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (launch) begin
            req_q   <= 1'b1;
            we_q    <= imem_wr_m;
            addr_q  <= {iaddr_m[MP_ADDR_WIDTH-1:2], 2'b00};
            be_q    <= be_d;
            wdata_q <= wdata_d;
          end
        end
        S_BUSY: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (ibus_ack) begin
            req_q <= 1'b0;
            if (!we_q) rdata_q <= ibus_rdata;
          end else if (timeout_hit) begin
            req_q     <= 1'b0;
            rdata_q   <= '0;
            timeout_q <= 1'b1;
          end
        end
        S_DONE:  cnt_q <= '0;
        default: cnt_q <= '0;
      endcase
    end
  end

  assign obus_req   = req_q;
  assign obus_we    = we_q;
  assign obus_addr  = addr_q;
  assign obus_be    = be_q;
  assign obus_wdata = wdata_q;
  assign ordata_m   = rdata_q;
  assign otimeout_m = timeout_q;

endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// Scoreboard bench for riscv_dmem_ctrl: expected bus/stall/read results are queued at
// drive time and popped when the controller reaches its DONE cycle.
module tb_riscv_dmem_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_wr, mem_rd;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [31:0] rdata_m;
  logic        stall, misalign, timeout;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          stalls;
    logic        to;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] last_rd = 32'h0;

  always #5 clk = ~clk;

  riscv_dmem_ctrl #(.MP_DATA_WIDTH(32), .MP_ADDR_WIDTH(32), .MP_TIMEOUT(TO)) dut (
    .iclk(clk), .irst(rst), .imem_wr_m(mem_wr), .imem_rd_m(mem_rd), .ifunct3_m(funct3),
    .iaddr_m(addr), .iwdata_m(wdata), .ordata_m(rdata_m), .ostall_m(stall),
    .omisalign_m(misalign), .otimeout_m(timeout), .obus_req(bus_req), .obus_we(bus_we),
    .obus_addr(bus_addr), .obus_be(bus_be), .obus_wdata(bus_wdata),
    .ibus_ack(bus_ack), .ibus_rdata(bus_rdata)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [3:0] model_be(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   case (a) 2'd0: return 4'b0001; 2'd1: return 4'b0010;
                        2'd2: return 4'b0100; default: return 4'b1000; endcase
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   return {d[7:0], d[7:0], d[7:0], d[7:0]};
      2'b01:   return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction

  task automatic idle_inputs();
    mem_wr = 1'b0; mem_rd = 1'b0; funct3 = 3'b010; addr = 32'h0; wdata = 32'h0;
  endtask

  // Aligned access; ack arrives in BUSY cycle ack_wait+1, or never when give_ack=0.
  task automatic access(input logic wr, input logic rd, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdv,
                        input int ack_wait, input bit give_ack);
    exp_t        e, got;
    int          stalls = 0;
    int          busy   = 0;
    bit          done   = 0;
    logic        c_we = 1'b0;
    logic [31:0] c_addr = 32'h0, c_wdata = 32'h0;
    logic [3:0]  c_be = 4'h0;
    e.we    = wr;
    e.addr  = {a[31:2], 2'b00};
    e.be    = model_be(f3[1:0], a[1:0]);
    e.wdata = model_wdata(f3[1:0], d);
    e.to    = !give_ack;
    if (give_ack) begin
      e.stalls = 2 + ack_wait;
      if (!wr) last_rd = rdv;
    end else begin
      e.stalls = 1 + TO;
      last_rd  = 32'h0;
    end
    e.rdata = last_rd;
    sb_q.push_back(e);

    @(negedge clk);
    mem_wr = wr; mem_rd = rd; funct3 = f3; addr = a; wdata = d;
    for (int c = 0; c < 100 && !done; c++) begin
      #1;
      if (!stall) done = 1;
      else begin
        stalls++;
        if (bus_req) begin
          busy++;
          if (busy == 1) begin
            c_we = bus_we; c_addr = bus_addr; c_be = bus_be; c_wdata = bus_wdata;
          end else begin
            check("bus_hold_addr", bus_addr, c_addr);
          end
          bus_ack   = give_ack && (busy == ack_wait + 1);
          bus_rdata = rdv;
        end
        @(negedge clk);
        bus_ack = 1'b0;
      end
    end
    if (!done) begin
      check("done_bound", 32'd0, 32'd1);
    end else begin
      got = sb_q.pop_front();
      check("stall_cycles", stalls, got.stalls);
      check("bus_we", {31'b0, c_we}, {31'b0, got.we});
      check("bus_addr", c_addr, got.addr);
      check("bus_be", {28'b0, c_be}, {28'b0, got.be});
      if (got.we) check("bus_wdata", c_wdata, got.wdata);
      check("rdata", rdata_m, got.rdata);
      check("timeout_pulse", {31'b0, timeout}, {31'b0, got.to});
      check("req_dropped", {31'b0, bus_req}, 32'd0);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    check("timeout_clear", {31'b0, timeout}, 32'd0);
    check("idle_no_stall", {31'b0, stall}, 32'd0);
  endtask

  task automatic misaligned(input logic wr, input logic rd, input logic [2:0] f3,
                            input logic [31:0] a);
    @(negedge clk);
    mem_wr = wr; mem_rd = rd; funct3 = f3; addr = a;
    #1;
    check("misalign_flag", {31'b0, misalign}, 32'd1);
    check("misalign_stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    #1;
    check("misalign_no_req", {31'b0, bus_req}, 32'd0);
    idle_inputs();
    #1;
    check("misalign_cleared", {31'b0, misalign}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; bus_ack = 1'b0; bus_rdata = 32'h0;
    idle_inputs();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_req", {31'b0, bus_req}, 32'd0);
    check("rst_be", {28'b0, bus_be}, 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    check("rst_wdata", bus_wdata, 32'd0);
    check("rst_rdata", rdata_m, 32'd0);
    check("rst_timeout", {31'b0, timeout}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);

    access(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 1'b1);
    access(1'b1, 1'b0, 3'b000, 32'h0000_0203, 32'h0000_00A5, 32'h1111_1111, 3, 1'b1);
    access(1'b1, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_1234, 32'h2222_2222, 1, 1'b1);
    access(1'b0, 1'b1, 3'b101, 32'h0000_0106, 32'h0, 32'hCAFE_F00D, 2, 1'b1);
    access(1'b1, 1'b0, 3'b000, 32'h0000_0401, 32'h0000_5A3C, 32'h0, 0, 1'b1);
    access(1'b0, 1'b1, 3'b100, 32'h0000_0402, 32'h0, 32'h0BAD_CAFE, 0, 1'b1);

    misaligned(1'b0, 1'b1, 3'b001, 32'h0000_0101);
    misaligned(1'b1, 1'b0, 3'b010, 32'h0000_0102);
    misaligned(1'b0, 1'b1, 3'b011, 32'h0000_0100);

    // Ack while idle must be ignored.
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    check("idle_ack_req", {31'b0, bus_req}, 32'd0);
    check("idle_ack_rdata", rdata_m, last_rd);

    access(1'b0, 1'b1, 3'b010, 32'h0000_0500, 32'h0, 32'h7777_7777, 0, 1'b0);

    access(1'b0, 1'b1, 3'b010, 32'h0000_0600, 32'h0, 32'h1357_9BDF, 0, 1'b1);
    // Reset in the middle of a bus access; a late ack must not resurrect it.
    @(negedge clk);
    mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h0000_0300;
    @(negedge clk);
    #1;
    check("pre_rst_req", {31'b0, bus_req}, 32'd1);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_req", {31'b0, bus_req}, 32'd0);
    check("mid_rst_addr", bus_addr, 32'd0);
    check("mid_rst_be", {28'b0, bus_be}, 32'd0);
    check("mid_rst_rdata", rdata_m, 32'd0);
    check("mid_rst_stall", {31'b0, stall}, 32'd0);
    bus_ack = 1'b1; bus_rdata = 32'h4444_4444;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    check("late_ack_req", {31'b0, bus_req}, 32'd0);
    check("late_ack_rdata", rdata_m, 32'd0);
    last_rd = 32'h0;

    access(1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'h0, 32'h8765_4321, 1, 1'b1);

    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
